// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 binary-convolution sequencer.
package conv_pkg;

  localparam logic [15:0] END_MARKER  = 16'hFFFF;
  localparam int          KERNEL_ROWS = 3;
  localparam int          PIPE_FLUSH  = 2;
  localparam int          MEM_LAT     = 1;
  localparam int          TMR_W       = 2;

  typedef enum logic [3:0] {
    IDLE, WDIM, WDATA, HDR_R, HDR_C, FILL, SCAN, FLUSH, WRITE, ADV, DONE
  } state_e;

  typedef struct packed {
    logic dut_busy_toggle;
    logic str_weights_dims;
    logic str_weights_data;
    logic str_input_nrows;
    logic str_input_ncols;
    logic incr_raddr_enable;
    logic pln_input_row_enable;
    logic incr_row_enable;
    logic rst_row_counter;
    logic incr_col_enable;
    logic rst_col_counter;
    logic update_d_in;
    logic str_temp_to_write;
    logic incr_waddr_enable;
    logic rst_output_row_temp;
    logic toggle_conv_go_flag;
  } strobes_t;

endpackage

// File: rtl/conv_ctrl_timer.sv
// Loadable saturating down-counter; zero flag tells the FSM a wait has expired.
module conv_ctrl_timer
  import conv_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         reset_b,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset_b) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/conv_controller.sv
// Sequencing FSM for the convolution datapath: weights, headers, row fill,
// column scans, pipeline flush and output-row writes, matrix after matrix.
module conv_controller
  import conv_pkg::*;
(
  input  logic        clk,
  input  logic        reset_b,
  input  logic        dut_run,
  input  logic        dut_busy,
  input  logic [15:0] sram_dut_read_data,
  input  logic        last_col_next,
  input  logic        last_row_flag,
  output logic        dut_busy_toggle,
  output logic        rst_dut_wmem_read_address,
  output logic        str_weights_dims,
  output logic        str_weights_data,
  output logic        str_input_nrows,
  output logic        str_input_ncols,
  output logic        incr_raddr_enable,
  output logic        pln_input_row_enable,
  output logic        incr_row_enable,
  output logic        rst_row_counter,
  output logic        incr_col_enable,
  output logic        rst_col_counter,
  output logic        update_d_in,
  output logic        str_temp_to_write,
  output logic        incr_waddr_enable,
  output logic        rst_output_row_temp,
  output logic        toggle_conv_go_flag
);

  state_e   state_q, state_d;
  strobes_t stb_q, stb_d;
  logic     wsel_q, wsel_d;

  logic             lat_load, lat_zero;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [TMR_W-1:0] cnt_val;

  conv_ctrl_timer #(.W(TMR_W)) u_lat (
    .clk(clk), .reset_b(reset_b), .load(lat_load),
    .load_val(TMR_W'(MEM_LAT)), .dec(1'b1), .zero(lat_zero)
  );

  conv_ctrl_timer #(.W(TMR_W)) u_cnt (
    .clk(clk), .reset_b(reset_b), .load(cnt_load),
    .load_val(cnt_val), .dec(cnt_dec), .zero(cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    stb_d    = '0;
    wsel_d   = wsel_q;
    lat_load = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    // The write enable is the falling edge of str_temp_to_write, so the
    // address bump and accumulator clear always trail it by one cycle.
    stb_d.incr_waddr_enable   = stb_q.str_temp_to_write;
    stb_d.rst_output_row_temp = stb_q.str_temp_to_write;
    case (state_q)
      IDLE: begin
        wsel_d                    = 1'b0;
        stb_d.rst_row_counter     = 1'b1;
        stb_d.rst_col_counter     = 1'b1;
        stb_d.rst_output_row_temp = 1'b1;
        if (dut_run && !dut_busy) begin
          stb_d.dut_busy_toggle = 1'b1;
          lat_load              = 1'b1;
          state_d               = WDIM;
        end
      end
      WDIM: if (lat_zero) begin
        stb_d.str_weights_dims = 1'b1;
        wsel_d                 = 1'b1;
        lat_load               = 1'b1;
        state_d                = WDATA;
      end
      WDATA: if (lat_zero) begin
        stb_d.str_weights_data = 1'b1;
        lat_load               = 1'b1;
        state_d                = HDR_R;
      end
      HDR_R: if (lat_zero) begin
        if (sram_dut_read_data == END_MARKER) begin
          state_d = DONE;
        end else begin
          stb_d.str_input_nrows   = 1'b1;
          stb_d.incr_raddr_enable = 1'b1;
          lat_load                = 1'b1;
          state_d                 = HDR_C;
        end
      end
      HDR_C: if (lat_zero) begin
        stb_d.str_input_ncols   = 1'b1;
        stb_d.incr_raddr_enable = 1'b1;
        lat_load                = 1'b1;
        cnt_load                = 1'b1;
        cnt_val                 = TMR_W'(KERNEL_ROWS - 1);
        state_d                 = FILL;
      end
      FILL: if (lat_zero) begin
        stb_d.pln_input_row_enable = 1'b1;
        stb_d.incr_raddr_enable    = 1'b1;
        stb_d.incr_row_enable      = 1'b1;
        if (cnt_zero) begin
          stb_d.rst_col_counter     = 1'b1;
          stb_d.toggle_conv_go_flag = 1'b1;
          state_d                   = SCAN;
        end else begin
          cnt_dec  = 1'b1;
          lat_load = 1'b1;
        end
      end
      SCAN: begin
        if (last_col_next) begin
          cnt_load = 1'b1;
          cnt_val  = TMR_W'(PIPE_FLUSH);
          state_d  = FLUSH;
        end else begin
          stb_d.update_d_in     = 1'b1;
          stb_d.incr_col_enable = 1'b1;
        end
      end
      FLUSH: begin
        if (cnt_zero) begin
          stb_d.toggle_conv_go_flag = 1'b1;
          state_d                   = WRITE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WRITE: begin
        stb_d.str_temp_to_write = 1'b1;
        lat_load                = 1'b1;
        state_d                 = last_row_flag ? HDR_R : ADV;
      end
      ADV: if (lat_zero) begin
        stb_d.pln_input_row_enable = 1'b1;
        stb_d.incr_raddr_enable    = 1'b1;
        stb_d.incr_row_enable      = 1'b1;
        stb_d.rst_col_counter      = 1'b1;
        stb_d.toggle_conv_go_flag  = 1'b1;
        state_d                    = SCAN;
      end
      DONE: begin
        stb_d.dut_busy_toggle = 1'b1;
        state_d               = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_b) begin
      state_q <= IDLE;
      stb_q   <= '0;
      wsel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      wsel_q  <= wsel_d;
    end
  end

  assign rst_dut_wmem_read_address = wsel_q;
  assign dut_busy_toggle           = stb_q.dut_busy_toggle;
  assign str_weights_dims          = stb_q.str_weights_dims;
  assign str_weights_data          = stb_q.str_weights_data;
  assign str_input_nrows           = stb_q.str_input_nrows;
  assign str_input_ncols           = stb_q.str_input_ncols;
  assign incr_raddr_enable         = stb_q.incr_raddr_enable;
  assign pln_input_row_enable      = stb_q.pln_input_row_enable;
  assign incr_row_enable           = stb_q.incr_row_enable;
  assign rst_row_counter           = stb_q.rst_row_counter;
  assign incr_col_enable           = stb_q.incr_col_enable;
  assign rst_col_counter           = stb_q.rst_col_counter;
  assign update_d_in               = stb_q.update_d_in;
  assign str_temp_to_write         = stb_q.str_temp_to_write;
  assign incr_waddr_enable         = stb_q.incr_waddr_enable;
  assign rst_output_row_temp       = stb_q.rst_output_row_temp;
  assign toggle_conv_go_flag       = stb_q.toggle_conv_go_flag;

endmodule

// File: tb/tb_conv_controller.sv
// Bench for conv_controller: a small datapath/memory model drives the inputs,
// and the expected strobe sequence is built from the matrix dimensions.
module tb_conv_controller;

  logic        clk = 1'b0;
  logic        reset_b = 1'b1;
  logic        dut_run = 1'b0;
  logic        dut_busy;
  logic [15:0] sram_dut_read_data;
  logic        last_col_next, last_row_flag;
  logic        dut_busy_toggle, rst_dut_wmem_read_address, str_weights_dims, str_weights_data;
  logic        str_input_nrows, str_input_ncols, incr_raddr_enable, pln_input_row_enable;
  logic        incr_row_enable, rst_row_counter, incr_col_enable, rst_col_counter;
  logic        update_d_in, str_temp_to_write, incr_waddr_enable, rst_output_row_temp;
  logic        toggle_conv_go_flag;

  always #5 clk = ~clk;

  conv_controller dut (
    .clk(clk), .reset_b(reset_b), .dut_run(dut_run), .dut_busy(dut_busy),
    .sram_dut_read_data(sram_dut_read_data), .last_col_next(last_col_next),
    .last_row_flag(last_row_flag), .dut_busy_toggle(dut_busy_toggle),
    .rst_dut_wmem_read_address(rst_dut_wmem_read_address),
    .str_weights_dims(str_weights_dims), .str_weights_data(str_weights_data),
    .str_input_nrows(str_input_nrows), .str_input_ncols(str_input_ncols),
    .incr_raddr_enable(incr_raddr_enable), .pln_input_row_enable(pln_input_row_enable),
    .incr_row_enable(incr_row_enable), .rst_row_counter(rst_row_counter),
    .incr_col_enable(incr_col_enable), .rst_col_counter(rst_col_counter),
    .update_d_in(update_d_in), .str_temp_to_write(str_temp_to_write),
    .incr_waddr_enable(incr_waddr_enable), .rst_output_row_temp(rst_output_row_temp),
    .toggle_conv_go_flag(toggle_conv_go_flag)
  );

  // strobe vector in a bench-local bit order
  localparam logic [15:0] S_BUSY = 16'h0001, S_WDIM = 16'h0002, S_WDAT = 16'h0004;
  localparam logic [15:0] S_NROW = 16'h0008, S_NCOL = 16'h0010, S_RADR = 16'h0020;
  localparam logic [15:0] S_PLN  = 16'h0040, S_IROW = 16'h0080, S_RROW = 16'h0100;
  localparam logic [15:0] S_ICOL = 16'h0200, S_RCOL = 16'h0400, S_UPD  = 16'h0800;
  localparam logic [15:0] S_TEMP = 16'h1000, S_WADR = 16'h2000, S_ROUT = 16'h4000;
  localparam logic [15:0] S_GO   = 16'h8000;
  localparam logic [15:0] V_IDLE  = S_RROW | S_RCOL | S_ROUT;
  localparam logic [15:0] V_START = V_IDLE | S_BUSY;
  localparam logic [15:0] V_ROW   = S_PLN | S_RADR | S_IROW;
  localparam logic [15:0] V_ROWGO = V_ROW | S_RCOL | S_GO;
  localparam logic [15:0] V_SCAN  = S_UPD | S_ICOL;
  localparam logic [15:0] V_WB    = S_WADR | S_ROUT;

  logic [15:0] vec;
  assign vec = {toggle_conv_go_flag, rst_output_row_temp, incr_waddr_enable, str_temp_to_write,
                update_d_in, rst_col_counter, incr_col_enable, rst_row_counter,
                incr_row_enable, pln_input_row_enable, incr_raddr_enable, str_input_ncols,
                str_input_nrows, str_weights_data, str_weights_dims, dut_busy_toggle};

  // ---------------- datapath / memory environment ----------------
  logic [15:0] sram [16];
  logic [15:0] raddr, waddr, row_cnt, col_cnt, nrows, ncols, sram_rd;
  logic        busy_q, wmem_prev, rst_q;

  always @(posedge clk) begin
    rst_q     <= reset_b;
    wmem_prev <= rst_dut_wmem_read_address;
    if (reset_b) begin
      busy_q <= 1'b0; raddr <= '0; waddr <= '0; row_cnt <= '0; col_cnt <= '0;
      nrows <= '0; ncols <= '0; sram_rd <= '0;
    end else begin
      sram_rd <= sram[raddr[3:0]];
      if (dut_busy_toggle)   busy_q <= ~busy_q;
      if (incr_raddr_enable) raddr <= raddr + 16'd1;
      if (incr_waddr_enable) waddr <= waddr + 16'd1;
      if (str_input_nrows)   nrows <= sram_rd;
      if (str_input_ncols)   ncols <= sram_rd;
      if (rst_row_counter || str_input_nrows) row_cnt <= '0;
      else if (incr_row_enable)               row_cnt <= row_cnt + 16'd1;
      if (rst_col_counter)      col_cnt <= '0;
      else if (incr_col_enable) col_cnt <= col_cnt + 16'd1;
    end
  end

  assign dut_busy           = busy_q;
  assign sram_dut_read_data = sram_rd;
  assign last_col_next      = (col_cnt == ncols - 16'd1);
  assign last_row_flag      = (row_cnt == nrows);

  // ---------------- model and checking ----------------
  int n_chk = 0, n_fail = 0;
  logic [15:0] exp_q [$];
  int exp_waddr;
  int cnt_toggle, cnt_nrows, cnt_icol, cnt_pln, cnt_write;
  logic [15:0] nrows_addr [4];
  logic temp_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_matrix(input int nr, input int nc);
    exp_q.push_back(S_NROW | S_RADR);
    exp_q.push_back(S_NCOL | S_RADR);
    exp_q.push_back(V_ROW);
    exp_q.push_back(V_ROW);
    exp_q.push_back(V_ROWGO);
    for (int r = 0; r < nr - 2; r++) begin
      if (r > 0) exp_q.push_back(V_ROWGO);
      for (int c = 0; c < nc; c++) exp_q.push_back(V_SCAN);
      exp_q.push_back(S_GO);
      exp_q.push_back(S_TEMP);
      exp_q.push_back(V_WB);
    end
  endtask

  task automatic push_start();
    exp_q.push_back(V_START);
    exp_q.push_back(S_WDIM);
    exp_q.push_back(S_WDAT);
  endtask

  always @(negedge clk) begin
    if (rst_q) begin
      check("reset_strobes", vec, 16'h0);
      check("reset_wmem_addr", rst_dut_wmem_read_address, 0);
      temp_prev = 1'b0;
    end else begin
      if (vec != 16'h0 && vec != V_IDLE) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_strobe: got %h expected none", vec);
        end else begin
          check("strobe_seq", vec, exp_q.pop_front());
        end
      end
      if (str_weights_dims) check("wdims_wmem_addr", wmem_prev, 0);
      if (str_weights_data) check("wdata_wmem_addr", wmem_prev, 1);
      if (vec == V_START)   check("start_when_idle_busy", busy_q, 0);
      if (vec == S_BUSY)    check("done_when_busy", busy_q, 1);
      if (temp_prev && !str_temp_to_write) begin
        check("write_addr", waddr, exp_waddr);
        exp_waddr++;
        cnt_write++;
      end
      if (str_input_nrows) begin
        if (cnt_nrows < 4) nrows_addr[cnt_nrows] = raddr;
        cnt_nrows++;
      end
      if (dut_busy_toggle)      cnt_toggle++;
      if (incr_col_enable)      cnt_icol++;
      if (pln_input_row_enable) cnt_pln++;
      temp_prev = str_temp_to_write;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input int n);
    reset_b = 1'b1;
    dut_run = 1'b0;
    tick(n);
    exp_q.delete();
    exp_waddr = 0; cnt_toggle = 0; cnt_nrows = 0; cnt_icol = 0; cnt_pln = 0; cnt_write = 0;
    reset_b = 1'b0;
    tick(2);
  endtask

  task automatic pulse_run();
    dut_run = 1'b1;
    tick(1);
    dut_run = 1'b0;
  endtask

  task automatic wait_toggles(input int target, input string name);
    int cyc;
    cyc = 0;
    while (cnt_toggle < target && cyc < 2000) begin tick(1); cyc++; end
    if (cnt_toggle < target) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: got %0d toggles expected %0d", name, cnt_toggle, target);
    end
    tick(4);
  endtask

  task automatic load_two_3x3();
    for (int i = 0; i < 16; i++) sram[i] = 16'h00A5;
    sram[0] = 16'd3; sram[1] = 16'd3; sram[5] = 16'd3; sram[6] = 16'd3;
    sram[10] = 16'hFFFF;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) sram[i] = 16'h0;

    // 1: reset and idle
    do_reset(3);
    tick(6);
    check("t1_no_toggle", cnt_toggle, 0);
    check("t1_wmem_addr", rst_dut_wmem_read_address, 0);

    // 2: end marker only
    sram[0] = 16'hFFFF;
    do_reset(3);
    push_start();
    exp_q.push_back(S_BUSY);
    pulse_run();
    wait_toggles(2, "t2");
    check("t2_toggles", cnt_toggle, 2);
    check("t2_nrows", cnt_nrows, 0);
    check("t2_drained", exp_q.size(), 0);

    // 3: one 4x4 matrix
    for (int i = 0; i < 16; i++) sram[i] = 16'h00A5;
    sram[0] = 16'd4; sram[1] = 16'd4; sram[6] = 16'hFFFF;
    do_reset(3);
    push_start();
    push_matrix(4, 4);
    exp_q.push_back(S_BUSY);
    pulse_run();
    wait_toggles(2, "t3");
    check("t3_incr_col", cnt_icol, 8);
    check("t3_row_shifts", cnt_pln, 4);
    check("t3_writes", cnt_write, 2);
    check("t3_busy_low", busy_q, 0);
    check("t3_drained", exp_q.size(), 0);

    // 4: two back-to-back 3x3 matrices
    load_two_3x3();
    do_reset(3);
    push_start();
    push_matrix(3, 3);
    push_matrix(3, 3);
    exp_q.push_back(S_BUSY);
    pulse_run();
    wait_toggles(2, "t4");
    check("t4_writes", cnt_write, 2);
    check("t4_nrows", cnt_nrows, 2);
    check("t4_hdr1_addr", nrows_addr[0], 0);
    check("t4_hdr2_addr", nrows_addr[1], 5);
    check("t4_final_raddr", raddr, 10);
    check("t4_drained", exp_q.size(), 0);

    // 5: reset during scan, then a clean rerun
    do_reset(3);
    push_start();
    push_matrix(3, 3);
    pulse_run();
    begin
      int cyc;
      cyc = 0;
      while (!update_d_in && cyc < 200) begin tick(1); cyc++; end
      check("t5_reached_scan", update_d_in, 1);
    end
    reset_b = 1'b1;
    tick(1);
    check("t5_abort_strobes", vec, 16'h0);
    check("t5_abort_wmem", rst_dut_wmem_read_address, 0);
    do_reset(1);
    push_start();
    push_matrix(3, 3);
    push_matrix(3, 3);
    exp_q.push_back(S_BUSY);
    pulse_run();
    wait_toggles(2, "t5");
    check("t5_writes", cnt_write, 2);
    check("t5_drained", exp_q.size(), 0);

    // 6: run held high across a complete job
    for (int i = 0; i < 16; i++) sram[i] = 16'h0;
    sram[0] = 16'hFFFF;
    do_reset(3);
    push_start(); exp_q.push_back(S_BUSY);
    push_start(); exp_q.push_back(S_BUSY);
    dut_run = 1'b1;
    wait_toggles(3, "t6_restart");
    dut_run = 1'b0;
    wait_toggles(4, "t6_done");
    tick(10);
    check("t6_toggles", cnt_toggle, 4);
    check("t6_busy_low", busy_q, 0);
    check("t6_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_controller.md
Name: conv_controller

Overview:
- Sequencing FSM for the 3x3 binary-convolution datapath.
- Accepts a run request, fetches the weight dimension and data words from weight memory, then reads each input matrix header.
- Streams the matrix rows through the datapath's 3-row pipeline and issues all column/row/address/write strobes.
- Processes matrices back to back until the end-marker header is read, then drops busy.
- Sits beside the datapath in the top level; it owns no data registers.

Parameters:
END_MARKER, 16'hFFFF, nrows header value that terminates processing
KERNEL_ROWS, 3, rows preloaded before the first column scan
PIPE_FLUSH, 2, idle cycles after the last column while the adder pipeline drains
MEM_LAT, 1, cycles from address change to valid read data (SRAM and weight memory)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_b  in  1  synchronous, active-high reset (sampled on clk; 1 = reset)
dut_run  in  1  start request from testbench/host
dut_busy  in  1  busy flag fed back from the datapath toggle flop
sram_dut_read_data  in  16  current input SRAM word (header check only)
last_col_next  in  1  datapath: the column counter just reached the last column
last_row_flag  in  1  datapath: the row counter just reached the last row
dut_busy_toggle  out  1  one-cycle pulse that flips dut_busy
rst_dut_wmem_read_address  out  1  0 = weight address held at 0; 1 = weight address 1
str_weights_dims  out  1  latch the weight dimension word
str_weights_data  out  1  latch the weight data word
str_input_nrows  out  1  latch the nrows header
str_input_ncols  out  1  latch the ncols header
incr_raddr_enable  out  1  advance the SRAM read address
pln_input_row_enable  out  1  shift a new row into the row pipeline
incr_row_enable  out  1  advance the row counter
rst_row_counter  out  1  clear the row counter
incr_col_enable  out  1  advance the column counter
rst_col_counter  out  1  clear the column counter
update_d_in  out  1  sample the 3-bit column slice
str_temp_to_write  out  1  copy the output row to write data (write fires on its falling edge)
incr_waddr_enable  out  1  advance the SRAM write address
rst_output_row_temp  out  1  clear the output row accumulator
toggle_conv_go_flag  out  1  flip conv_go_flag at scan start and scan end

Behaviour:
- All outputs are registered decodes of state.
- While reset_b=1: state=IDLE; every strobe=0; rst_dut_wmem_read_address=0.
- Reset mid-operation aborts immediately, with no flush and no write.

State transitions (per-state strobes in brackets):
- IDLE [rst_dut_wmem_read_address=0, rst_row_counter=1, rst_col_counter=1, rst_output_row_temp=1]:
  - dut_run=1 and dut_busy=0: pulse dut_busy_toggle, go to WDIM.
  - dut_run while dut_busy=1 is ignored.
- WDIM: wait MEM_LAT cycles, then str_weights_dims=1 for 1 cycle and raise rst_dut_wmem_read_address to 1 (held until IDLE); go to WDATA.
- WDATA: wait MEM_LAT cycles, then str_weights_data=1 for 1 cycle; go to HDR_R.
- HDR_R: wait MEM_LAT cycles, then test sram_dut_read_data.
  - Equals END_MARKER: go to DONE.
  - Otherwise: str_input_nrows=1 and incr_raddr_enable=1; go to HDR_C.
- HDR_C: wait MEM_LAT cycles, then str_input_ncols=1 and incr_raddr_enable=1; go to FILL.
- FILL, KERNEL_ROWS iterations with a 2-bit fill counter:
  - Each iteration waits MEM_LAT cycles, then pulses pln_input_row_enable, incr_raddr_enable and incr_row_enable together.
  - After the 3rd iteration: rst_col_counter=1 and toggle_conv_go_flag=1; go to SCAN.
- SCAN: update_d_in=1 and incr_col_enable=1 every cycle; on last_col_next=1, go to FLUSH.
- FLUSH: PIPE_FLUSH cycles with no strobes (flush counter); then toggle_conv_go_flag=1; go to WRITE.
- WRITE (1 cycle): str_temp_to_write=1.
  - The next cycle always asserts incr_waddr_enable=1 and rst_output_row_temp=1, so the datapath write enable fires exactly once per output row.
  - last_row_flag=1 at that cycle: go to HDR_R for the next matrix.
  - Otherwise: go to ADV.
- ADV: wait MEM_LAT cycles; pulse pln_input_row_enable, incr_raddr_enable, incr_row_enable; then rst_col_counter=1 and toggle_conv_go_flag=1; go to SCAN.
- DONE: pulse dut_busy_toggle for 1 cycle; go to IDLE.

Width and boundary rules:
- Fill and flush counters saturate and are cleared on state entry.
- Header compare is a full 16-bit equality.
- A matrix with nrows=KERNEL_ROWS produces exactly one output row (WRITE to HDR_R with no ADV).
- last_col_next and last_row_flag arriving in the same cycle are both honoured: the column finishes first, then the row exit is taken after WRITE.
- Simultaneous dut_run with reset: reset wins.

Decomposition:
- Shared package conv_pkg:
  - state enum (IDLE, WDIM, WDATA, HDR_R, HDR_C, FILL, SCAN, FLUSH, WRITE, ADV, DONE)
  - END_MARKER, KERNEL_ROWS, PIPE_FLUSH, MEM_LAT
  - strobe-bundle struct used by the top-level connect
- Natural sub-module: conv_ctrl_timer, a small loadable down-counter shared by the MEM_LAT waits, the fill count and the flush count, with a zero flag back to the FSM.

Test Plan:
1. reset_b=1 for 3 cycles, then 0 -> state IDLE; all strobes 0; rst_dut_wmem_read_address=0; dut_busy_toggle never pulses.
2. Memory with weights, then header 16'hFFFF at SRAM[0]; dut_run=1 -> exactly two dut_busy_toggle pulses; str_input_nrows never asserted.
3. One 4x4 matrix followed by END_MARKER -> 3 FILL pulses, 2 SCAN passes of 4 incr_col_enable each, 2 write-enable pulses at write addresses 0 and 1, then busy drops.
4. Two back-to-back 3x3 matrices -> one WRITE per matrix; the second HDR_R read occurs at read address 5; busy drops after the third header.
5. reset_b asserted during SCAN -> next cycle state=IDLE and all strobes 0; a new dut_run afterwards re-reads the weights at weight address 0.
6. dut_run held high throughout processing -> no extra busy toggle while busy; after DONE, IDLE restarts on the still-high dut_run only once dut_busy=0.
